shift_scheduler: RTL

Shared-shifter scheduler for the processor/graphics datapath. Two requesters share one 32-bit barrel shift unit: port 0 is the CPU execute stage, port 1 is the Tetris row/piece engine. The block arbitrates round-robin, latches the winning request, performs one shift (sll/srl/sra/ror), and holds the result until the owning port accepts it. All handshakes are valid/ready; one operation is in flight at a time.

---
 rtl/shift_scheduler_if.sv | 31 +++
 rtl/shift_scheduler.sv | 125 ++++++++++++
 2 files changed

// File: rtl/shift_scheduler_if.sv
// Request/response bundle between the two shifter clients and shift_scheduler.
// Port 0 is the CPU execute stage; port 1 is the Tetris row/piece engine.
interface shift_scheduler_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 2;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [DATA_W-1:0]  req_data0;
  logic [DATA_W-1:0]  req_data1;
  logic [SHAMT_W-1:0] req_shamt0;
  logic [SHAMT_W-1:0] req_shamt1;
  logic [OP_W-1:0]    req_op0;
  logic [OP_W-1:0]    req_op1;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [DATA_W-1:0]  resp_data;

  modport master (
    output req_valid, req_data0, req_data1, req_shamt0, req_shamt1,
           req_op0, req_op1, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_shamt0, req_shamt1,
           req_op0, req_op1, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/shift_scheduler.sv
// Round-robin arbiter in front of one shared 32-bit barrel shifter.
// One operation in flight: IDLE accepts, EXEC shifts, RESP holds result for the owner.
module shift_scheduler (
  input  logic              clock,
  input  logic              reset,
  shift_scheduler_if.slave  bus,
  output logic              busy
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [SHAMT_W-1:0]  shamt_q, shamt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [1:0]          resp_valid_q, resp_valid_d;
  logic                busy_q, busy_d;

  logic [1:0]          grant_c;
  logic [DATA_W-1:0]   shift_res_c;
  logic [2*DATA_W-1:0] rot_c;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_c = 2'b00;
    case (bus.req_valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  // Rotate is the low half of the doubled operand shifted right, so shamt=0 is a no-op.
  always_comb begin
    rot_c = {opnd_q, opnd_q} >> shamt_q;
    case (op_q)
      2'b00:   shift_res_c = opnd_q << shamt_q;
      2'b01:   shift_res_c = opnd_q >> shamt_q;
      2'b10:   shift_res_c = DATA_W'($signed(opnd_q) >>> shamt_q);
      default: shift_res_c = rot_c[DATA_W-1:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    opnd_d       = opnd_q;
    shamt_d      = shamt_q;
    op_d         = op_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      IDLE: begin
        if (grant_c != 2'b00) begin
          owner_d      = grant_c[1];
          last_grant_d = grant_c[1];
          opnd_d       = grant_c[1] ? bus.req_data1  : bus.req_data0;
          shamt_d      = grant_c[1] ? bus.req_shamt1 : bus.req_shamt0;
          op_d         = grant_c[1] ? bus.req_op1    : bus.req_op0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_data_d  = shift_res_c;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 2'b00;
        state_d      = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      opnd_q       <= '0;
      shamt_q      <= '0;
      op_q         <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      opnd_q       <= opnd_d;
      shamt_q      <= shamt_d;
      op_q         <= op_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Grant is offered only in IDLE and never while reset is held.
  assign bus.req_ready  = (reset && (state_q == IDLE)) ? grant_c : 2'b00;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = busy_q;
endmodule
